// File: rtl/bank_account_responder.sv
// ATM bank-account responder: 4 accounts, PIN-verified sessions, deposit/withdraw/balance.
// Latency: response registered 2 cycles after acceptance; held until resp_ready; one request in flight.
// Optional PIN_LOCKOUT_EN: consecutive wrong PINs lock an account until reset.
module bank_account_responder #(
    parameter logic [7:0] CARD_BASE  = 8'h01,
    parameter logic [3:0] PIN_BASE   = 4'h5,
    parameter logic [4:0] INIT_BAL   = 5'd10,
    parameter logic [1:0] LOCK_LIMIT = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cardno,
    input  logic [3:0] req_pin,
    input  logic [2:0] req_cmd,
    input  logic [4:0] req_amount,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [2:0] resp_status,
    output logic [4:0] resp_balance
);
    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EXEC, S_RESP} state_t;

    localparam logic [2:0] CMD_DEP = 3'b001, CMD_WD  = 3'b010, CMD_BAL = 3'b011,
                           CMD_VER = 3'b100, CMD_END = 3'b101;
    localparam logic [2:0] ST_OK = 3'd0, ST_BAD_CARD = 3'd1, ST_BAD_PIN = 3'd2,
                           ST_INSUF = 3'd3, ST_OVERFLOW = 3'd4, ST_LOCKED = 3'd5,
                           ST_BAD_REQ = 3'd6, ST_NOT_AUTH = 3'd7;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cardno;
    logic [3:0] r_pin;
    logic [2:0] r_cmd;
    logic [4:0] r_amt;
    logic       r_hit;
    logic [1:0] r_idx;
    logic [4:0] r_bal [4];
    logic       r_sess_vld;
    logic [1:0] r_sess_idx;
    logic [2:0] r_resp_status;
    logic [4:0] r_resp_bal;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cardno <= '0;
            r_pin    <= '0;
            r_cmd    <= '0;
            r_amt    <= '0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_cardno <= req_cardno;
            r_pin    <= req_pin;
            r_cmd    <= req_cmd;
            r_amt    <= req_amount;
        end
    end

    logic [7:0] w_diff;
    assign w_diff = r_cardno - CARD_BASE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit <= 1'b0;
            r_idx <= '0;
        end else if (r_state == S_LOOKUP) begin
            r_hit <= (w_diff < 8'd4);
            r_idx <= w_diff[1:0];
        end
    end

    logic [4:0] w_cur_bal;
    logic [5:0] w_sum;
    logic [3:0] w_pin_exp;
    logic       w_auth;
    logic       w_locked;
    logic       w_cmd_legal;
    logic       w_amt_cmd;
    logic       w_needs_auth;

    assign w_cur_bal    = r_bal[r_idx];
    assign w_sum        = {1'b0, w_cur_bal} + {1'b0, r_amt};
    assign w_pin_exp    = PIN_BASE + {2'b00, r_idx};
    assign w_auth       = r_sess_vld && (r_sess_idx == r_idx);
    assign w_cmd_legal  = (r_cmd >= CMD_DEP) && (r_cmd <= CMD_END);
    assign w_amt_cmd    = (r_cmd == CMD_DEP) || (r_cmd == CMD_WD);
    assign w_needs_auth = w_amt_cmd || (r_cmd == CMD_BAL);

    logic [2:0] w_status;
    logic [4:0] w_new_bal;
    logic       w_bal_we;
    logic       w_sess_set;
    logic       w_sess_clr;

    always_comb begin
        w_status   = ST_OK;
        w_new_bal  = w_cur_bal;
        w_bal_we   = 1'b0;
        w_sess_set = 1'b0;
        w_sess_clr = 1'b0;
        if (!r_hit) begin
            w_status  = ST_BAD_CARD;
            w_new_bal = '0;
        end else if (w_locked) begin
            w_status = ST_LOCKED;
        end else if (!w_cmd_legal || (w_amt_cmd && r_amt == 5'd0)) begin
            w_status = ST_BAD_REQ;
        end else if (w_needs_auth && !w_auth) begin
            w_status = ST_NOT_AUTH;
        end else begin
            case (r_cmd)
                CMD_DEP: begin
                    if (w_sum > 6'd31) w_status = ST_OVERFLOW;
                    else begin
                        w_new_bal = w_sum[4:0];
                        w_bal_we  = 1'b1;
                    end
                end
                CMD_WD: begin
                    if (r_amt > w_cur_bal) w_status = ST_INSUF;
                    else begin
                        w_new_bal = w_cur_bal - r_amt;
                        w_bal_we  = 1'b1;
                    end
                end
                CMD_VER: begin
                    if (r_pin == w_pin_exp) w_sess_set = 1'b1;
                    else begin
                        w_status   = ST_BAD_PIN;
                        w_sess_clr = 1'b1;
                    end
                end
                CMD_END: w_sess_clr = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_bal[i] <= INIT_BAL;
            r_sess_vld    <= 1'b0;
            r_sess_idx    <= '0;
            r_resp_status <= ST_OK;
            r_resp_bal    <= '0;
        end else if (r_state == S_EXEC) begin
            if (w_bal_we) r_bal[r_idx] <= w_new_bal;
            if (w_sess_set) begin
                r_sess_vld <= 1'b1;
                r_sess_idx <= r_idx;
            end else if (w_sess_clr) begin
                r_sess_vld <= 1'b0;
            end
            r_resp_status <= w_status;
            r_resp_bal    <= w_new_bal;
        end
    end

`ifdef PIN_LOCKOUT_EN
    logic [1:0] r_fail [4];
    logic [3:0] r_lock;

    assign w_locked = r_lock[r_idx];

    // Lock is set by the wrong PIN that brings the count to the limit; that response is still BAD_PIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_fail[i] <= '0;
            r_lock <= '0;
        end else if (r_state == S_EXEC && r_cmd == CMD_VER) begin
            if (w_status == ST_OK) begin
                r_fail[r_idx] <= '0;
            end else if (w_status == ST_BAD_PIN) begin
                if (r_fail[r_idx] != 2'd3) r_fail[r_idx] <= r_fail[r_idx] + 2'd1;
                if (({1'b0, r_fail[r_idx]} + 3'd1) >= {1'b0, LOCK_LIMIT}) r_lock[r_idx] <= 1'b1;
            end
        end
    end
`else
    assign w_locked = 1'b0;
`endif

    assign resp_status  = r_resp_status;
    assign resp_balance = r_resp_bal;
endmodule

// File: tb/tb_bank_account_responder.sv
// Randomized and directed bench for bank_account_responder against a behavioural account model.
module tb_bank_account_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cardno;
    logic [3:0] req_pin;
    logic [2:0] req_cmd;
    logic [4:0] req_amount;
    logic       resp_valid;
    logic       resp_ready;
    logic [2:0] resp_status;
    logic [4:0] resp_balance;

    bank_account_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cardno   (req_cardno),
        .req_pin      (req_pin),
        .req_cmd      (req_cmd),
        .req_amount   (req_amount),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_status  (resp_status),
        .resp_balance (resp_balance)
    );

    always #5 clk = ~clk;

    localparam int OK = 0, BAD_CARD = 1, BAD_PIN = 2, INSUF = 3, OVERFLOW = 4,
                   LOCKED = 5, BAD_REQ = 6, NOT_AUTH = 7;

    int n_checks = 0;
    int n_errors = 0;

    int m_bal [4];
    int m_fail [4];
    bit m_lock [4];
    bit m_sess;
    int m_sidx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bal[i]  = 10;
            m_fail[i] = 0;
            m_lock[i] = 1'b0;
        end
        m_sess = 1'b0;
        m_sidx = 0;
    endtask

    // Account rules: cards 1..4, PIN 5+index, balances 0..31.
    task automatic model(input int c, input int p, input int cmd, input int a,
                         output int st, output int b);
        int idx;
        if (c < 1 || c > 4) begin
            st = BAD_CARD;
            b  = 0;
            return;
        end
        idx = c - 1;
        st  = OK;
        if (m_lock[idx]) st = LOCKED;
        else if (cmd < 1 || cmd > 5 || ((cmd == 1 || cmd == 2) && a == 0)) st = BAD_REQ;
        else if (cmd <= 3 && !(m_sess && m_sidx == idx)) st = NOT_AUTH;
        else if (cmd == 1) begin
            if (m_bal[idx] + a > 31) st = OVERFLOW;
            else m_bal[idx] = m_bal[idx] + a;
        end else if (cmd == 2) begin
            if (a > m_bal[idx]) st = INSUF;
            else m_bal[idx] = m_bal[idx] - a;
        end else if (cmd == 4) begin
            if (p == (5 + idx) % 16) begin
                m_sess = 1'b1;
                m_sidx = idx;
                m_fail[idx] = 0;
            end else begin
                st = BAD_PIN;
                m_sess = 1'b0;
                if (m_fail[idx] < 3) m_fail[idx]++;
`ifdef PIN_LOCKOUT_EN
                if (m_fail[idx] >= 3) m_lock[idx] = 1'b1;
`endif
            end
        end else if (cmd == 5) m_sess = 1'b0;
        b = m_bal[idx];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_status", 32'(resp_status), 0);
        check("rst_balance", 32'(resp_balance), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Entered and left at a negedge with the DUT idle; junk on req_* while busy must be ignored.
    task automatic send(input logic [7:0] c, input logic [3:0] p, input logic [2:0] cmd,
                        input logic [4:0] a, input int hold,
                        output logic [2:0] gs, output logic [4:0] gb);
        int es, eb, n;
        model(int'(c), int'(p), int'(cmd), int'(a), es, eb);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 1);
        req_valid  = 1'b1;
        req_cardno = c;
        req_pin    = p;
        req_cmd    = cmd;
        req_amount = a;
        @(negedge clk);
        n = 0;
        while (!resp_valid && n < 8) begin
            check("req_ready_busy", 32'(req_ready), 0);
            req_cardno = 8'($urandom);
            req_pin    = 4'($urandom);
            req_cmd    = 3'($urandom);
            req_amount = 5'($urandom);
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check("latency", 32'(n), 2);
        gs = resp_status;
        gb = resp_balance;
        check("status", 32'(resp_status), 32'(es));
        check("balance", 32'(resp_balance), 32'(eb));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_status", 32'(resp_status), 32'(es));
            check("hold_balance", 32'(resp_balance), 32'(eb));
            check("hold_req_ready", 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_released", 32'(resp_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] gs;
        logic [4:0] gb;
        int r, idx;
        logic [7:0] c;
        logic [3:0] p;
        logic [2:0] cmd;
        logic [4:0] a;

        rst = 1'b1; req_valid = 1'b0; req_cardno = '0; req_pin = '0;
        req_cmd = '0; req_amount = '0; resp_ready = 1'b0;
        model_reset();
        do_reset();

        send(8'h02, 4'h6, 3'b100, 5'd0, 0, gs, gb);
        check("d_verify_st", 32'(gs), OK);      check("d_verify_bal", 32'(gb), 10);
        send(8'h02, 4'h6, 3'b001, 5'd5, 5, gs, gb);
        check("d_dep5_st", 32'(gs), OK);        check("d_dep5_bal", 32'(gb), 15);
        send(8'h02, 4'h6, 3'b010, 5'd15, 0, gs, gb);
        check("d_wd15_st", 32'(gs), OK);        check("d_wd15_bal", 32'(gb), 0);

        send(8'h01, 4'h5, 3'b001, 5'd3, 0, gs, gb);
        check("d_noauth_st", 32'(gs), NOT_AUTH); check("d_noauth_bal", 32'(gb), 10);
        send(8'h09, 4'h5, 3'b011, 5'd0, 1, gs, gb);
        check("d_badcard_st", 32'(gs), BAD_CARD); check("d_badcard_bal", 32'(gb), 0);

        send(8'h01, 4'h5, 3'b100, 5'd0, 0, gs, gb);
        send(8'h01, 4'h5, 3'b001, 5'd22, 0, gs, gb);
        check("d_ovf_st", 32'(gs), OVERFLOW);   check("d_ovf_bal", 32'(gb), 10);
        send(8'h01, 4'h5, 3'b010, 5'd11, 0, gs, gb);
        check("d_insuf_st", 32'(gs), INSUF);    check("d_insuf_bal", 32'(gb), 10);
        send(8'h01, 4'h5, 3'b010, 5'd0, 0, gs, gb);
        check("d_wd0_st", 32'(gs), BAD_REQ);
        send(8'h01, 4'h5, 3'b111, 5'd1, 0, gs, gb);
        check("d_illegal_st", 32'(gs), BAD_REQ); check("d_illegal_bal", 32'(gb), 10);

        for (int k = 0; k < 3; k++) begin
            send(8'h01, 4'h0, 3'b100, 5'd0, 0, gs, gb);
            check("d_badpin_st", 32'(gs), BAD_PIN);
        end
        send(8'h01, 4'h5, 3'b100, 5'd0, 0, gs, gb);
`ifdef PIN_LOCKOUT_EN
        check("d_locked_st", 32'(gs), LOCKED);
`else
        check("d_unlocked_st", 32'(gs), OK);
`endif
        check("d_lock_bal", 32'(gb), 10);

        do_reset();
        send(8'h03, 4'h7, 3'b100, 5'd0, 0, gs, gb);
        req_valid = 1'b1; req_cardno = 8'h03; req_pin = 4'h7; req_cmd = 3'b001; req_amount = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("inflight_rst_valid", 32'(resp_valid), 0);
        check("inflight_rst_ready", 32'(req_ready), 1);
        rst = 1'b0;
        model_reset();
        send(8'h03, 4'h7, 3'b100, 5'd0, 0, gs, gb);
        send(8'h03, 4'h7, 3'b011, 5'd0, 0, gs, gb);
        check("inflight_bal", 32'(gb), 10);

        for (int it = 0; it < 300; it++) begin
            if (it % 80 == 79) do_reset();
            r = $urandom_range(9, 0);
            if (r < 8)       c = 8'(1 + r % 4);
            else if (r == 8) c = 8'h00;
            else             c = 8'($urandom_range(255, 5));
            idx = int'(c) - 1;
            if ($urandom_range(3, 0) != 0) p = 4'((5 + idx) % 16);
            else                           p = 4'($urandom);
            r = $urandom_range(9, 0);
            if (r < 3)       cmd = 3'b100;
            else if (r < 5)  cmd = 3'b001;
            else if (r < 7)  cmd = 3'b010;
            else if (r == 7) cmd = 3'b011;
            else if (r == 8) cmd = 3'b101;
            else             cmd = 3'($urandom);
            a = ($urandom_range(4, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            send(c, p, cmd, a, $urandom_range(2, 0), gs, gb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bank_account_responder.md
BANK_ACCOUNT_RESPONDER -- requirements
Module: bank_account_responder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- CARD_BASE, 8'h01, card number of account 0; accounts 0..3 are CARD_BASE..CARD_BASE+3.
- PIN_BASE, 4'h5, PIN of account 0; account i PIN = PIN_BASE+i (mod 16).
- INIT_BAL, 5'd10, reset balance of every account.
- LOCK_LIMIT, 2'd3, consecutive wrong PINs that lock an account.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, ATM request present.
- req_ready, output, 1, responder can accept a request.
- req_cardno, input, 8, card number.
- req_pin, input, 4, entered PIN.
- req_cmd, input, 3, 001 deposit, 010 withdraw, 011 balance, 100 verify PIN, 101 end session, others illegal.
- req_amount, input, 5, deposit/withdraw amount.
- resp_valid, output, 1, response present.
- resp_ready, input, 1, ATM accepts response.
- resp_status, output, 3, 000 OK, 001 BAD_CARD, 010 BAD_PIN, 011 INSUFFICIENT, 100 OVERFLOW, 101 LOCKED, 110 BAD_REQ, 111 NOT_AUTH.
- resp_balance, output, 5, account balance after the operation.

Function
REQ-003 The FSM SHALL have states IDLE, LOOKUP, EXEC, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-004 Request accepted on edge E0 with req_valid&&req_ready; all req_* fields SHALL be captured at E0; LOOKUP after E0, EXEC after E1, RESP after E2 (resp_valid visible 2 cycles after acceptance).
REQ-005 LOOKUP SHALL match captured cardno to an account index; no match -> status BAD_CARD, resp_balance=0, no state change.
REQ-006 Status priority in EXEC: BAD_CARD > LOCKED > BAD_REQ (illegal cmd, or amount 0 on deposit/withdraw) > NOT_AUTH > command-specific.
REQ-007 Verify PIN: match -> OK, session={valid, index}, fail counter cleared; mismatch -> BAD_PIN, session cleared, fail counter +1 (saturating).
REQ-008 Deposit/withdraw/balance SHALL require an active session on the same account, else NOT_AUTH.
REQ-009 Deposit: balance+amount > 31 -> OVERFLOW, balance unchanged; else OK, balance += amount (6-bit intermediate sum).
REQ-010 Withdraw: amount > balance -> INSUFFICIENT, unchanged; amount == balance allowed (result 0) -> OK.
REQ-011 End session: clears session, status OK regardless of auth (card must be valid and unlocked).
REQ-012 resp_balance SHALL be the post-operation balance of the matched account for all statuses except BAD_CARD.
REQ-013 Status and balance SHALL be registered at E2 and remain stable while resp_valid=1 until resp_valid&&resp_ready; FSM then returns to IDLE; next acceptance no earlier than the following edge.
REQ-014 req_valid while not in IDLE SHALL be ignored (no capture).

Reset
REQ-015 rst=1 at an edge SHALL force IDLE, req_ready=1, resp_valid=0, resp_status=000, resp_balance=0, all balances=INIT_BAL, fail counters=0, locks cleared, session cleared; any in-flight request is discarded with no balance update.

Configuration
REQ-016 Macro PIN_LOCKOUT_EN defined: fail counter reaching LOCK_LIMIT locks the account; locked accounts return LOCKED for every command until reset. Undefined: no counters/locks; wrong PIN always BAD_PIN; LOCKED never produced.

Verification
REQ-017 Reset; verify card 8'h02 PIN 4'h6 -> OK, bal 10; deposit 5 -> OK, bal 15; withdraw 15 -> OK, bal 0.
REQ-018 Deposit 3 on card 8'h01 without verify -> NOT_AUTH, bal 10; card 8'h09 any cmd -> BAD_CARD, bal 0.
REQ-019 After verify, deposit 22 on bal 10 -> OVERFLOW, bal 10; withdraw 11 -> INSUFFICIENT; withdraw 0 -> BAD_REQ; cmd 3'b111 -> BAD_REQ.
REQ-020 With PIN_LOCKOUT_EN: three wrong PINs on 8'h01 -> BAD_PIN, BAD_PIN, BAD_PIN, then correct PIN 4'h5 -> LOCKED; without macro correct PIN -> OK.
REQ-021 Hold resp_ready=0 5 cycles -> resp_valid/status stable, req_ready=0; assert rst during EXEC of deposit 4 -> balance remains 10, resp_valid=0 next cycle.
